// File: rtl/rr_stream_arbiter.sv
// ----------------------------------------------------------------------------
// rr_stream_arbiter
//   Shares one downstream valid/ready byte channel between NUM_REQ upstream
//   requesters. Round-robin grant feeds a registered output stage that can be
//   drained and reloaded in the same cycle, so a continuous stream runs at one
//   beat per cycle with no bubble when the winner changes.
//
//   Optional feature (macro ARB_PKT_LOCK_EN): adds the req_last_i port and a
//   two-state lock FSM. Once a requester starts a multi-beat packet, it owns
//   the channel until it sends the beat marked last.
//
// Ports
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_data_i   requester k data at [k*DATA_W +: DATA_W]
//   req_ready_o  per-requester ready, at most one bit high, 0 during reset
//   e_ready_i    downstream ready
//   e_valid_o    downstream valid (registered)
//   e_data_o     downstream data (registered)
//   e_src_o      index of the requester that supplied e_data_o (registered)
//   req_last_i   last beat of packet (ARB_PKT_LOCK_EN only)
// ----------------------------------------------------------------------------

// Per-requester slice: qualifies the grant with the output-register state and
// masks the data so the top level can merge lanes with a plain OR.
module rr_stream_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              grant_i,
    input  logic              can_load_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              take_o,
    output logic [DATA_W-1:0] data_o
);
    // Ready is gated by reset so nothing is accepted while reset is asserted.
    assign ready_o = grant_i & can_load_i & rst_n_i;
    assign take_o  = ready_o & valid_i;
    assign data_o  = take_o ? data_i : '0;
endmodule

module rr_stream_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      e_ready_i,
    output logic                      e_valid_o,
    output logic [DATA_W-1:0]         e_data_o,
    output logic [SRC_W-1:0]          e_src_o
`ifdef ARB_PKT_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]        req_last_i
`endif
);
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    // (base + off) mod NUM_REQ, valid for off < NUM_REQ; also works for
    // non-power-of-two requester counts.
    function automatic logic [SRC_W-1:0] idx_add(input logic [SRC_W-1:0] base,
                                                 input int unsigned       off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ_U) s = s - NUM_REQ_U;
        return s[SRC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              e_valid_q, e_valid_d;
    logic [DATA_W-1:0] e_data_q,  e_data_d;
    logic [SRC_W-1:0]  e_src_q,   e_src_d;
    logic [SRC_W-1:0]  ptr_q,     ptr_d;

    // ------------------------------------------------------------------
    // Round-robin search starting at ptr_q
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] rr_oh;
    logic [SRC_W-1:0]   rr_idx;
    logic               rr_any;

    always_comb begin
        rr_oh  = '0;
        rr_idx = ptr_q;
        rr_any = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ_U; off++) begin
            if (!rr_any && req_valid_i[idx_add(ptr_q, off)]) begin
                rr_any = 1'b1;
                rr_idx = idx_add(ptr_q, off);
            end
        end
        rr_oh[rr_idx] = rr_any;
    end

    // ------------------------------------------------------------------
    // Grant selection and lanes
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]             grant_oh;
    logic [SRC_W-1:0]               grant_idx;
    logic                           can_load;
    logic [NUM_REQ-1:0]             lane_ready;
    logic [NUM_REQ-1:0]             lane_take;
    logic [NUM_REQ-1:0][DATA_W-1:0] lane_data;
    logic                           take;
    logic [DATA_W-1:0]              take_data;

    // The register may load when empty or when its current beat leaves
    // this cycle; the latter gives full throughput with no bubble.
    assign can_load = ~e_valid_q | e_ready_i;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        rr_stream_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .grant_i    (grant_oh[k]),
            .can_load_i (can_load),
            .rst_n_i    (reset_n),
            .valid_i    (req_valid_i[k]),
            .data_i     (req_data_i[k*DATA_W +: DATA_W]),
            .ready_o    (lane_ready[k]),
            .take_o     (lane_take[k]),
            .data_o     (lane_data[k])
        );
    end

    assign req_ready_o = lane_ready;
    assign take        = |lane_take;

    // Lanes present zero unless they transfer, and at most one transfers.
    always_comb begin
        take_data = '0;
        for (int k = 0; k < NUM_REQ; k++) take_data = take_data | lane_data[k];
    end

`ifdef ARB_PKT_LOCK_EN
    // ------------------------------------------------------------------
    // Packet lock FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e      state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;

    // While locked only the owner can win; if it has nothing to send the
    // channel idles rather than letting another requester interleave.
    always_comb begin
        grant_oh  = rr_oh;
        grant_idx = rr_idx;
        if (state_q == ST_LOCKED) begin
            grant_oh           = '0;
            grant_oh[owner_q]  = req_valid_i[owner_q];
            grant_idx          = owner_q;
        end
    end

    // The pointer only moves when a packet completes, so the requester after
    // the packet's owner is first in line next.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (req_last_i[grant_idx]) begin
                        ptr_d = idx_add(grant_idx, 1);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = grant_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (take && req_last_i[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_add(owner_q, 1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    // Every beat is arbitrated on its own.
    always_comb begin
        grant_oh  = rr_oh;
        grant_idx = rr_idx;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take) ptr_d = idx_add(grant_idx, 1);
    end
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // A new beat replaces the current one (drain and load together); with no
    // new beat and a downstream accept the register empties but keeps its
    // data/src so those lines do not toggle needlessly.
    always_comb begin
        e_valid_d = e_valid_q;
        e_data_d  = e_data_q;
        e_src_d   = e_src_q;
        if (take) begin
            e_valid_d = 1'b1;
            e_data_d  = take_data;
            e_src_d   = grant_idx;
        end else if (e_ready_i) begin
            e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid_q <= 1'b0;
            e_data_q  <= '0;
            e_src_q   <= '0;
            ptr_q     <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_data_q  <= e_data_d;
            e_src_q   <= e_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign e_valid_o = e_valid_q;
    assign e_data_o  = e_data_q;
    assign e_src_o   = e_src_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_stream_arbiter
//   Directed bench for rr_stream_arbiter (NUM_REQ=4, DATA_W=8). Each step
//   checks req_ready_o against the expected grant, pushes the accepted beat
//   onto a scoreboard queue, and pops/compares whenever the output beat is
//   handed downstream. The packet-lock scenario runs when ARB_PKT_LOCK_EN is
//   defined.
// ----------------------------------------------------------------------------
module tb_rr_stream_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int SRC_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        rv;
    logic [NUM_REQ*DATA_W-1:0] rd;
    logic [NUM_REQ-1:0]        rdy;
    logic                      erdy;
    logic                      e_valid;
    logic [DATA_W-1:0]         e_data;
    logic [SRC_W-1:0]          e_src;
`ifdef ARB_PKT_LOCK_EN
    logic [NUM_REQ-1:0]        rl;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    rr_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (rv),
        .req_data_i  (rd),
        .req_ready_o (rdy),
        .e_ready_i   (erdy),
        .e_valid_o   (e_valid),
        .e_data_o    (e_data),
        .e_src_o     (e_src)
`ifdef ARB_PKT_LOCK_EN
        ,
        .req_last_i  (rl)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge with this cycle's inputs set.
    // Checks ready mid-cycle, scores the accept, then advances one cycle.
    task automatic step(input logic [NUM_REQ-1:0] exp_rdy);
        logic [15:0] e;
        #3;
        chk("req_ready", 32'(rdy), 32'(exp_rdy));
        if (e_valid && erdy) begin
            chk("beat_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("e_src", 32'(e_src), 32'(e[15:8]));
                chk("e_data", 32'(e_data), 32'(e[7:0]));
            end
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (exp_rdy[k] && rv[k]) sb.push_back({8'(k), rd[k*DATA_W +: DATA_W]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        rv      = 4'b1111;
        rd      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        erdy    = 1'b1;
`ifdef ARB_PKT_LOCK_EN
        rl      = 4'b1111;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state with every requester valid.
        chk("rst_e_valid", 32'(e_valid), 32'd0);
        chk("rst_e_data", 32'(e_data), 32'd0);
        chk("rst_e_src", 32'(e_src), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);

        // Continuous stream from all four: 0,1,2,3,0,1 at one beat per cycle.
        reset_n = 1'b1;
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        rv = 4'b0000;
        step(4'b0000);
        chk("drain_e_valid", 32'(e_valid), 32'd0);

        // Backpressure: pointer is at 2, only requester 2 valid.
        rv = 4'b0100;
        rd = {8'h00, 8'h5C, 8'h00, 8'h00};
        step(4'b0100);
        erdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_e_valid", 32'(e_valid), 32'd1);
            chk("stall_e_data", 32'(e_data), 32'h5C);
            chk("stall_e_src", 32'(e_src), 32'd2);
            step(4'b0000);
        end
        erdy = 1'b1;
        rv   = 4'b0000;
        step(4'b0000);
        chk("bp_e_valid", 32'(e_valid), 32'd0);

        // Fairness and wrap: pointer at 3, requesters 1 and 3 valid.
        rv = 4'b1010;
        rd = {8'h33, 8'h00, 8'h11, 8'h00};
        step(4'b1000);
        step(4'b0010);
        step(4'b1000);
        rv = 4'b0000;
        step(4'b0000);
        chk("wrap_e_valid", 32'(e_valid), 32'd0);

        // Reset during a stall discards the held beat and restarts at req 0.
        rv = 4'b0010;
        rd = {8'h00, 8'h00, 8'h77, 8'h00};
        step(4'b0010);
        erdy = 1'b0;
        rv   = 4'b0000;
        step(4'b0000);
        chk("pre_rst_e_valid", 32'(e_valid), 32'd1);
        rv      = 4'b1111;
        reset_n = 1'b0;
        #1;
        chk("async_rst_e_valid", 32'(e_valid), 32'd0);
        chk("async_rst_e_data", 32'(e_data), 32'd0);
        chk("async_rst_e_src", 32'(e_src), 32'd0);
        chk("async_rst_ready", 32'(rdy), 32'd0);
        sb.delete();
        rv = 4'b0000;
        #1;
        reset_n = 1'b1;
        erdy    = 1'b1;
        @(posedge clk);
        #1;
        rv = 4'b1111;
        rd = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        step(4'b0001);
        rv = 4'b0000;
        step(4'b0000);

`ifdef ARB_PKT_LOCK_EN
        // Packet lock: pointer back to 0, req 0 sends three beats while
        // req 1 stays valid; req 1 must wait for the last beat.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rv = 4'b0011;
        rl = 4'b0010;
        rd = {8'h00, 8'h00, 8'hC1, 8'hB0};
        step(4'b0001);
        rd = {8'h00, 8'h00, 8'hC1, 8'hB1};
        step(4'b0001);
        rv = 4'b0010;
        step(4'b0000);
        rv = 4'b0011;
        rl = 4'b0011;
        rd = {8'h00, 8'h00, 8'hC1, 8'hB2};
        step(4'b0001);
        rv = 4'b0010;
        step(4'b0010);
        rv = 4'b0000;
        step(4'b0000);
        chk("lock_e_valid", 32'(e_valid), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
